// File: rtl/multiplier_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier:
// FSM state encoding and the iteration-counter width helper.
package multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that has to reach bits-1.
    function automatic int count_width(input int bits);
        return (bits <= 2) ? 1 : $clog2(bits);
    endfunction

endpackage

// File: rtl/seq_multiplier_mag_negate.sv
// Conditional two's-complement negate. Used to take |operand| at load time
// and to restore the sign of the finished product.
module mag_negate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    // ~x+1 wraps zero back to zero, so a negated zero stays zero.
    assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier: one multiplier bit per cycle, LSB first,
// BITS busy cycles plus one DONE cycle per product. Signed mode works on
// magnitudes and re-applies the product sign when the result is loaded.
module seq_multiplier
    import multiplier_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int SIGNED = 0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [BITS-1:0]   i_multiplier,
    input  logic [BITS-1:0]   i_multiplicand,
    output logic              o_busy,
    output logic              o_finished,
    output logic [2*BITS-1:0] o_product
);

    localparam int CW = count_width(BITS);

    state_t            r_state;
    state_t            w_next_state;
    logic [BITS-1:0]   r_mplier;
    logic [2*BITS-1:0] r_mcand;
    logic [2*BITS-1:0] r_acc;
    logic              r_sign;
    logic [CW-1:0]     r_count;
    logic [2*BITS-1:0] r_product;

    logic              w_accept;
    logic              w_last;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [BITS-1:0]   w_mag_a;
    logic [BITS-1:0]   w_mag_b;
    logic [2*BITS-1:0] w_acc_next;
    logic [2*BITS-1:0] w_result;

    // A start is only honoured when no multiply is in flight.
    assign w_accept = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_state == ST_BUSY) && (r_count == CW'(BITS - 1));

    // Sign bits only matter in signed mode; unsigned mode latches operands as-is.
    assign w_neg_a  = (SIGNED != 0) && i_multiplier[BITS-1];
    assign w_neg_b  = (SIGNED != 0) && i_multiplicand[BITS-1];

    // The accumulator is 2*BITS wide, so this sum can never overflow.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    mag_negate #(.WIDTH(BITS)) u_abs_a (
        .i_value  (i_multiplier),
        .i_negate (w_neg_a),
        .o_value  (w_mag_a)
    );

    mag_negate #(.WIDTH(BITS)) u_abs_b (
        .i_value  (i_multiplicand),
        .i_negate (w_neg_b),
        .o_value  (w_mag_b)
    );

    mag_negate #(.WIDTH(2*BITS)) u_result (
        .i_value  (w_acc_next),
        .i_negate (r_sign),
        .o_value  (w_result)
    );

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: DONE lasts one cycle and can chain straight into BUSY.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next_state = ST_BUSY;
            ST_BUSY: if (w_last)  w_next_state = ST_DONE;
            ST_DONE: w_next_state = i_start ? ST_BUSY : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        o_busy     = (r_state == ST_BUSY);
        o_finished = (r_state == ST_DONE);
    end

    // Datapath: load magnitudes on accept, one shift-and-add step per busy cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mplier  <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_sign    <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mplier <= w_mag_a;
            r_mcand  <= {{BITS{1'b0}}, w_mag_b};
            r_acc    <= '0;
            r_sign   <= w_neg_a ^ w_neg_b;
            r_count  <= '0;
        end else if (r_state == ST_BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
            if (w_last) begin
                r_product <= w_result;
            end
        end
    end

    assign o_product = r_product;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised iterative shift-and-add multiplier producing a full-width 2*BITS product from two BITS-wide operands.
- Next generation of the one-hot-sequenced multiplier datapath: adds a real operand/product interface, busy/finished handshake, back-to-back operation and an optional signed (two's-complement) mode.
- Used wherever a low-area multi-cycle multiply is acceptable; one multiply per BITS+1 cycles.

Parameters:
- BITS, 8, operand width; legal range 2..32.
- SIGNED, 0, 0 = unsigned operands and product; 1 = two's-complement operands and product.

Ports:
- i_clock  input  1  sole clock; all state updates on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request; sampled every edge, accepted only in IDLE or DONE.
- i_multiplier  input  BITS  operand A; sampled only on an accepted start.
- i_multiplicand  input  BITS  operand B; sampled only on an accepted start.
- o_busy  output  1  high while in BUSY.
- o_finished  output  1  single-cycle pulse; high exactly while in DONE.
- o_product  output  2*BITS  registered result; valid from DONE onward and held until the next DONE.

Behaviour:
- Reset: synchronous, active-high. State returns to IDLE and all internal registers clear. o_busy=0, o_finished=0, o_product=0.
- States:
  - IDLE: waits for start.
  - BUSY: iterates; cycle counter runs 0..BITS-1.
  - DONE: one cycle.
- Transitions:
  - IDLE -> BUSY on i_start=1.
  - BUSY -> DONE when counter==BITS-1.
  - DONE -> BUSY if i_start=1, giving back-to-back operation; otherwise DONE -> IDLE.
- Accept at edge k:
  - Operands are latched and the counter cleared.
  - The accumulator is cleared.
  - SIGNED=1: magnitudes |A|, |B| are latched as BITS-bit unsigned values, and result sign = A[BITS-1] ^ B[BITS-1] is stored.
  - SIGNED=0: operands are latched unchanged and the sign is forced to 0.
- BUSY iteration, one bit per cycle, LSB first:
  - If the current multiplier bit is 1, the accumulator (2*BITS wide) adds the multiplicand register; the multiplicand register then shifts left by 1.
  - The multiplier register shifts right by 1.
  - No overflow is possible: the accumulator is sized 2*BITS.
- Latency:
  - o_busy is high for edges k+1..k+BITS, i.e. BITS cycles.
  - o_finished and the new o_product appear after edge k+BITS+1 and stay valid for that one cycle.
  - o_product is then held until overwritten.
- Result: o_product <= sign ? (~acc + 1) : acc, loaded on entry to DONE only.
- Boundary and corner cases:
  - i_start while BUSY: ignored. Operands are not resampled and there is no queueing.
  - i_start in DONE: accepted. o_finished still pulses that cycle, and the next o_busy follows immediately.
  - Most-negative operands (SIGNED=1), e.g. BITS=8, -128 * -128: magnitude 128 fits BITS unsigned; product 0x4000 fits the 2*BITS signed range.
  - Zero operand: iteration still takes BITS cycles (fixed latency, no early exit); product 0, never negative zero, since ~0+1 wraps to 0.
  - Reset mid-operation (BUSY or DONE): abort to IDLE with o_product=0, no o_finished pulse; a start asserted in the same cycle as reset is ignored.
  - Operand inputs may change freely while BUSY without affecting the result.

Decomposition:
- Shared package (multiplier_pkg):
  - State encoding constants ST_IDLE, ST_BUSY, ST_DONE; 2-bit binary encoding.
  - Counter-width helper: clog2(BITS).
- Single module, no sub-module required.
- Optional natural split: a combinational sign-magnitude helper, mag_negate, used both for |operand| at load and for the final result negate.

Test Plan:
- BITS=8 unsigned, start with A=13, B=11 -> o_busy high 8 cycles; o_finished pulses at edge k+9 with o_product=0x008F; product held afterwards.
- BITS=8 unsigned, A=255, B=255 -> 0xFE01; then A=0, B=200 -> 0x0000, still 9-cycle latency.
- BITS=8 SIGNED=1:
  - -3 * 5 -> 0xFFF1
  - -128 * -128 -> 0x4000
  - 127 * -128 -> 0xC080
- Start pulsed again with different operands mid-BUSY -> ignored; original product delivered at the original cycle. Start held high in DONE -> back-to-back second result exactly BITS+1 cycles after the first.
- Reset asserted at BUSY cycle 4 -> next cycle o_busy=0, o_product=0; no o_finished pulse; a subsequent start runs normally.
- BITS=16, unsigned and SIGNED=1, 1000 random operand pairs vs reference model -> exact match with fixed 17-cycle latency.
